control_unit: RTL and testbench

Microcoded sequencer that is the consumer of the instruction register's opcode nibble and the producer of every bus-control strobe in the 8-bit CPU. It steps a 5-state T-counter and decodes step, opcode and flags into the read/write enables of the PC, MAR, RAM, IR, A, B, ALU and output registers. It also owns fetch, instruction termination and halt.

---
 rtl/control_unit.sv | 199 +++++++++++++++++++
 tb/tb_control_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Microcoded T-step sequencer for the 8-bit CPU: decodes step, opcode and flags
// into the bus-control strobes and owns fetch, instruction termination and halt.
module control_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    i_CLOCK,
    input  logic                    i_CLEAR_N,
    input  logic [DATA_WIDTH/2-1:0] i_OPCODE,
    input  logic                    i_CARRY,
    input  logic                    i_ZERO,
    output logic                    o_PC_INC,
    output logic                    o_PC_WRITE_BUS,
    output logic                    o_PC_LOAD,
    output logic                    o_MAR_READ_BUS,
    output logic                    o_RAM_READ_BUS,
    output logic                    o_RAM_WRITE_BUS,
    output logic                    o_IR_READ_BUS,
    output logic                    o_IR_WRITE_BUS,
    output logic                    o_A_READ_BUS,
    output logic                    o_A_WRITE_BUS,
    output logic                    o_B_READ_BUS,
    output logic                    o_ALU_WRITE_BUS,
    output logic                    o_ALU_SUB,
    output logic                    o_FLAGS_LOAD,
    output logic                    o_OUT_READ_BUS,
    output logic [2:0]              o_STEP,
    output logic                    o_HALTED
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    typedef struct packed {
        logic pc_inc;
        logic pc_write;
        logic pc_load;
        logic mar_read;
        logic ram_read;
        logic ram_write;
        logic ir_read;
        logic ir_write;
        logic a_read;
        logic a_write;
        logic b_read;
        logic alu_write;
        logic alu_sub;
        logic flags_load;
        logic out_read;
    } ctrl_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_e      r_step;
    logic       r_halted;
    step_e      w_step_next;
    logic       w_halted_next;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;
    logic [3:0] w_op;

    // Wider opcode fields carry extra bits above the decoded nibble.
    assign w_op = i_OPCODE[3:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_CLOCK or negedge i_CLEAR_N) begin
        if (!i_CLEAR_N) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else begin
            r_step   <= w_step_next;
            r_halted <= w_halted_next;
        end
    end

    // NOTE: every combinational output gets a default before the case
    // statements, so no path leaves a signal unassigned and no latch appears.
    always_comb begin
        w_step_next   = T0;
        w_halted_next = r_halted;
        w_ctrl        = '0;
        if (r_halted) begin
            w_step_next = r_step;
        end else begin
            unique case (r_step)
                T0: begin
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.mar_read = 1'b1;
                    w_step_next     = T1;
                end
                T1: begin
                    w_ctrl.ram_write = 1'b1;
                    w_ctrl.ir_read   = 1'b1;
                    w_ctrl.pc_inc    = 1'b1;
                    w_step_next      = T2;
                end
                T2: begin
                    case (w_op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            w_ctrl.ir_write = 1'b1;
                            w_ctrl.mar_read = 1'b1;
                            w_step_next     = T3;
                        end
                        OP_LDI: begin
                            w_ctrl.ir_write = 1'b1;
                            w_ctrl.a_read   = 1'b1;
                        end
                        OP_JMP: begin
                            w_ctrl.ir_write = 1'b1;
                            w_ctrl.pc_load  = 1'b1;
                        end
                        OP_JC: begin
                            w_ctrl.ir_write = i_CARRY;
                            w_ctrl.pc_load  = i_CARRY;
                        end
                        OP_JZ: begin
                            w_ctrl.ir_write = i_ZERO;
                            w_ctrl.pc_load  = i_ZERO;
                        end
                        OP_OUT: begin
                            w_ctrl.a_write  = 1'b1;
                            w_ctrl.out_read = 1'b1;
                        end
                        OP_HLT: begin
                            // Park on T2 so o_STEP reads 2 while halted.
                            w_halted_next = 1'b1;
                            w_step_next   = T2;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (w_op)
                        OP_LDA: begin
                            w_ctrl.ram_write = 1'b1;
                            w_ctrl.a_read    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            w_ctrl.ram_write = 1'b1;
                            w_ctrl.b_read    = 1'b1;
                            w_step_next      = T4;
                        end
                        OP_STA: begin
                            w_ctrl.a_write  = 1'b1;
                            w_ctrl.ram_read = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (w_op == OP_ADD || w_op == OP_SUB) begin
                        w_ctrl.alu_write  = 1'b1;
                        w_ctrl.a_read     = 1'b1;
                        w_ctrl.flags_load = 1'b1;
                        w_ctrl.alu_sub    = (w_op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: strobes are gated by the reset pin itself so they drop the moment
    // reset asserts, not at the next clock edge.
    assign w_out = i_CLEAR_N ? w_ctrl : '0;

    assign o_PC_INC        = w_out.pc_inc;
    assign o_PC_WRITE_BUS  = w_out.pc_write;
    assign o_PC_LOAD       = w_out.pc_load;
    assign o_MAR_READ_BUS  = w_out.mar_read;
    assign o_RAM_READ_BUS  = w_out.ram_read;
    assign o_RAM_WRITE_BUS = w_out.ram_write;
    assign o_IR_READ_BUS   = w_out.ir_read;
    assign o_IR_WRITE_BUS  = w_out.ir_write;
    assign o_A_READ_BUS    = w_out.a_read;
    assign o_A_WRITE_BUS   = w_out.a_write;
    assign o_B_READ_BUS    = w_out.b_read;
    assign o_ALU_WRITE_BUS = w_out.alu_write;
    assign o_ALU_SUB       = w_out.alu_sub;
    assign o_FLAGS_LOAD    = w_out.flags_load;
    assign o_OUT_READ_BUS  = w_out.out_read;
    assign o_STEP          = r_step;
    assign o_HALTED        = r_halted;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, multi-cycle
// reset/halt sequences and a random instruction stream against a reference model.
module tb_control_unit;

    logic       clk;
    logic       clear_n;
    logic [3:0] opcode;
    logic       carry;
    logic       zero;
    logic       pc_inc, pc_write, pc_load, mar_read, ram_read, ram_write;
    logic       ir_read, ir_write, a_read, a_write, b_read;
    logic       alu_write, alu_sub, flags_load, out_read;
    logic [2:0] step;
    logic       halted;

    int n_checks = 0;
    int n_pass   = 0;

    control_unit #(.DATA_WIDTH(8)) dut (
        .i_CLOCK        (clk),
        .i_CLEAR_N      (clear_n),
        .i_OPCODE       (opcode),
        .i_CARRY        (carry),
        .i_ZERO         (zero),
        .o_PC_INC       (pc_inc),
        .o_PC_WRITE_BUS (pc_write),
        .o_PC_LOAD      (pc_load),
        .o_MAR_READ_BUS (mar_read),
        .o_RAM_READ_BUS (ram_read),
        .o_RAM_WRITE_BUS(ram_write),
        .o_IR_READ_BUS  (ir_read),
        .o_IR_WRITE_BUS (ir_write),
        .o_A_READ_BUS   (a_read),
        .o_A_WRITE_BUS  (a_write),
        .o_B_READ_BUS   (b_read),
        .o_ALU_WRITE_BUS(alu_write),
        .o_ALU_SUB      (alu_sub),
        .o_FLAGS_LOAD   (flags_load),
        .o_OUT_READ_BUS (out_read),
        .o_STEP         (step),
        .o_HALTED       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [14:0] S_PC_INC = 15'd1 << 14;
    localparam logic [14:0] S_PC_W   = 15'd1 << 13;
    localparam logic [14:0] S_PC_LD  = 15'd1 << 12;
    localparam logic [14:0] S_MAR_R  = 15'd1 << 11;
    localparam logic [14:0] S_RAM_R  = 15'd1 << 10;
    localparam logic [14:0] S_RAM_W  = 15'd1 << 9;
    localparam logic [14:0] S_IR_R   = 15'd1 << 8;
    localparam logic [14:0] S_IR_W   = 15'd1 << 7;
    localparam logic [14:0] S_A_R    = 15'd1 << 6;
    localparam logic [14:0] S_A_W    = 15'd1 << 5;
    localparam logic [14:0] S_B_R    = 15'd1 << 4;
    localparam logic [14:0] S_ALU_W  = 15'd1 << 3;
    localparam logic [14:0] S_SUB    = 15'd1 << 2;
    localparam logic [14:0] S_FL     = 15'd1 << 1;
    localparam logic [14:0] S_OUT_R  = 15'd1;
    localparam logic [14:0] WB_MASK  = S_PC_W | S_RAM_W | S_IR_W | S_A_W | S_ALU_W;
    localparam logic [14:0] FETCH0   = S_PC_W | S_MAR_R;
    localparam logic [14:0] FETCH1   = S_RAM_W | S_IR_R | S_PC_INC;

    logic [14:0] act;
    assign act = {pc_inc, pc_write, pc_load, mar_read, ram_read, ram_write, ir_read,
                  ir_write, a_read, a_write, b_read, alu_write, alu_sub, flags_load, out_read};

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (halted,step,strobes)", name, got, exp);
    endtask

    // Compare the full observable state {halted, step, strobes}.
    task automatic check_state(input string name, input logic exp_h, input logic [2:0] exp_step,
                               input logic [14:0] exp_s);
        check(name, {halted, step, act}, {exp_h, exp_step, exp_s});
    endtask

    // One clock cycle: entered at posedge+1, drives inputs, samples at posedge+4.
    task automatic do_cycle(input string name, input logic [3:0] op, input logic c,
                            input logic z, input logic [2:0] exp_step, input logic [14:0] exp_s);
        opcode = op;
        carry  = c;
        zero   = z;
        #3;
        check_state(name, 1'b0, exp_step, exp_s);
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-instruction microprogram indexed by cycle-in-instruction.
    function automatic int instr_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic logic [14:0] micro(input logic [3:0] op, input int k,
                                          input logic c, input logic z);
        if (k == 0) return FETCH0;
        if (k == 1) return FETCH1;
        if (k == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: return S_IR_W | S_MAR_R;
                4'h5: return S_IR_W | S_A_R;
                4'h6: return S_IR_W | S_PC_LD;
                4'h7: return c ? (S_IR_W | S_PC_LD) : 15'd0;
                4'h8: return z ? (S_IR_W | S_PC_LD) : 15'd0;
                4'hE: return S_A_W | S_OUT_R;
                default: return 15'd0;
            endcase
        end
        if (k == 3) begin
            case (op)
                4'h1:       return S_RAM_W | S_A_R;
                4'h2, 4'h3: return S_RAM_W | S_B_R;
                4'h4:       return S_A_W | S_RAM_R;
                default:    return 15'd0;
            endcase
        end
        if (op == 4'h2) return S_ALU_W | S_A_R | S_FL;
        if (op == 4'h3) return S_ALU_W | S_A_R | S_FL | S_SUB;
        return 15'd0;
    endfunction

    // Run an instruction from cycle k0 with random flags and junk opcode before T2.
    task automatic run_model(input logic [3:0] op, input int k0, input bit check_inv);
        logic [3:0] drive_op;
        logic c, z;
        for (int k = k0; k < instr_len(op); k++) begin
            drive_op = (k < 2) ? 4'($urandom_range(0, 15)) : op;
            c = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            opcode = drive_op;
            carry  = c;
            zero   = z;
            #3;
            check_state($sformatf("model op=%h k=%0d", op, k), 1'b0, 3'(k), micro(op, k, c, z));
            if (check_inv) begin
                check("one_write_bus", {18'd0, ($countones(act & WB_MASK) <= 1)}, 19'd1);
                check("step_le_4", {18'd0, (step <= 3'd4)}, 19'd1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        c;
        logic        z;
        int          len;
        logic [14:0] e2;
        logic [14:0] e3;
        logic [14:0] e4;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"NOP",   4'h0, 1'b0, 1'b0, 3, 15'd0, 15'd0, 15'd0};
        vecs[1]  = '{"SUB",   4'h3, 1'b1, 1'b1, 5, S_IR_W | S_MAR_R, S_RAM_W | S_B_R,
                     S_ALU_W | S_A_R | S_FL | S_SUB};
        vecs[2]  = '{"JC_c0", 4'h7, 1'b0, 1'b1, 3, 15'd0, 15'd0, 15'd0};
        vecs[3]  = '{"JC_c1", 4'h7, 1'b1, 1'b0, 3, S_IR_W | S_PC_LD, 15'd0, 15'd0};
        vecs[4]  = '{"JZ_z0", 4'h8, 1'b1, 1'b0, 3, 15'd0, 15'd0, 15'd0};
        vecs[5]  = '{"JZ_z1", 4'h8, 1'b0, 1'b1, 3, S_IR_W | S_PC_LD, 15'd0, 15'd0};
        vecs[6]  = '{"LDA",   4'h1, 1'b0, 1'b0, 4, S_IR_W | S_MAR_R, S_RAM_W | S_A_R, 15'd0};
        vecs[7]  = '{"ADD",   4'h2, 1'b0, 1'b0, 5, S_IR_W | S_MAR_R, S_RAM_W | S_B_R,
                     S_ALU_W | S_A_R | S_FL};
        vecs[8]  = '{"STA",   4'h4, 1'b0, 1'b0, 4, S_IR_W | S_MAR_R, S_A_W | S_RAM_R, 15'd0};
        vecs[9]  = '{"LDI",   4'h5, 1'b0, 1'b0, 3, S_IR_W | S_A_R, 15'd0, 15'd0};
        vecs[10] = '{"JMP",   4'h6, 1'b0, 1'b0, 3, S_IR_W | S_PC_LD, 15'd0, 15'd0};
        vecs[11] = '{"OUT",   4'hE, 1'b0, 1'b0, 3, S_A_W | S_OUT_R, 15'd0, 15'd0};

        clear_n = 1'b0;
        opcode  = 4'h2;
        carry   = 1'b0;
        zero    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset_state", 1'b0, 3'd0, 15'd0);

        // Release mid-cycle: T0 strobes must appear before any edge.
        clear_n = 1'b1;
        do_cycle("nop_c0", 4'h0, 1'b0, 1'b0, 3'd0, FETCH0);
        do_cycle("nop_c1", 4'h0, 1'b0, 1'b0, 3'd1, FETCH1);
        do_cycle("nop_c2", 4'h0, 1'b0, 1'b0, 3'd2, 15'd0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].len; k++) begin
                logic [14:0] e;
                e = (k == 0) ? FETCH0 : (k == 1) ? FETCH1 :
                    (k == 2) ? vecs[i].e2 : (k == 3) ? vecs[i].e3 : vecs[i].e4;
                do_cycle($sformatf("%s_T%0d", vecs[i].name, k),
                         (k < 2) ? 4'($urandom_range(0, 15)) : vecs[i].op,
                         vecs[i].c, vecs[i].z, 3'(k), e);
            end
        end
        do_cycle("wrap_to_T0", 4'h0, 1'b0, 1'b0, 3'd0, FETCH0);
        do_cycle("wrap_T1", 4'h0, 1'b0, 1'b0, 3'd1, FETCH1);
        do_cycle("wrap_T2", 4'h0, 1'b0, 1'b0, 3'd2, 15'd0);

        // Carry changing inside T2 must move PC_LOAD within the same cycle.
        do_cycle("jc_live_T0", 4'h0, 1'b0, 1'b0, 3'd0, FETCH0);
        do_cycle("jc_live_T1", 4'h0, 1'b0, 1'b0, 3'd1, FETCH1);
        opcode = 4'h7;
        carry  = 1'b0;
        #1;
        check_state("jc_live_c0", 1'b0, 3'd2, 15'd0);
        carry = 1'b1;
        #1;
        check_state("jc_live_c1", 1'b0, 3'd2, S_IR_W | S_PC_LD);
        @(posedge clk);
        #1;

        do_cycle("hlt_T0", 4'h0, 1'b0, 1'b0, 3'd0, FETCH0);
        do_cycle("hlt_T1", 4'h0, 1'b0, 1'b0, 3'd1, FETCH1);
        do_cycle("hlt_T2", 4'hF, 1'b0, 1'b0, 3'd2, 15'd0);
        for (int n = 0; n < 20; n++) begin
            opcode = 4'($urandom_range(0, 15));
            carry  = 1'($urandom_range(0, 1));
            zero   = 1'($urandom_range(0, 1));
            #3;
            check_state($sformatf("halted_%0d", n), 1'b1, 3'd2, 15'd0);
            @(posedge clk);
            #1;
        end
        clear_n = 1'b0;
        #1;
        check_state("hlt_reset_low", 1'b0, 3'd0, 15'd0);
        clear_n = 1'b1;
        #1;
        check_state("hlt_release_T0", 1'b0, 3'd0, FETCH0);
        @(posedge clk);
        #1;
        run_model(4'h0, 1, 1'b0);

        // Abort LDA in T3 with a reset pulse between edges.
        do_cycle("lda_abort_T0", 4'h0, 1'b0, 1'b0, 3'd0, FETCH0);
        do_cycle("lda_abort_T1", 4'h0, 1'b0, 1'b0, 3'd1, FETCH1);
        do_cycle("lda_abort_T2", 4'h1, 1'b0, 1'b0, 3'd2, S_IR_W | S_MAR_R);
        #1;
        check_state("lda_abort_T3", 1'b0, 3'd3, S_RAM_W | S_A_R);
        #1;
        clear_n = 1'b0;
        #1;
        check_state("lda_abort_low", 1'b0, 3'd0, 15'd0);
        @(posedge clk);
        #1;
        check_state("lda_abort_held", 1'b0, 3'd0, 15'd0);
        clear_n = 1'b1;
        #1;
        check_state("lda_abort_restart", 1'b0, 3'd0, FETCH0);
        @(posedge clk);
        #1;
        run_model(4'h1, 1, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            run_model(4'($urandom_range(0, 14)), 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
